// File: rtl/lcd_phy_arbiter.sv
// Round-robin arbiter granting one of N requesters exclusive use of a single
// registered LCD PHY byte path for a whole multi-beat transaction.
module lcd_phy_arbiter #(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*N-1:0] usr_data,
    input  logic [N-1:0]   usr_rs,
    input  logic [N-1:0]   usr_last,
    input  logic [N-1:0]   usr_valid,
    output logic [N-1:0]   usr_ready,
    output logic [7:0]     phy_data,
    output logic           phy_rs,
    output logic           phy_valid,
    input  logic           phy_ready,
    output logic [2:0]     gnt_id,
    output logic           busy
);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_gnt_id;
    logic [2:0] r_last_id;
    logic [7:0] r_phy_data;
    logic       r_phy_rs;
    logic       r_phy_valid;

    logic       w_rr_found;
    logic [2:0] w_rr_id;
    logic       w_own_valid;
    logic       w_own_last;
    logic       w_own_rs;
    logic [7:0] w_own_data;
    logic       w_can_load;
    logic       w_accept;

    // Owner's request signals, selected by comparing against each constant
    // index so a 3-bit grant never indexes past a narrow request vector.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_rs    = 1'b0;
        w_own_data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (r_gnt_id == 3'(i)) begin
                w_own_valid = usr_valid[i];
                w_own_last  = usr_last[i];
                w_own_rs    = usr_rs[i];
                w_own_data  = usr_data[8*i +: 8];
            end
        end
    end

    // Search starts just above the previous owner and wraps, first hit wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_id    = 3'd0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_rr_found && usr_valid[i] &&
                    (((int'(r_last_id) + 1 + k) % N) == i)) begin
                    w_rr_found = 1'b1;
                    w_rr_id    = 3'(i);
                end
            end
        end
    end

    assign w_can_load = !r_phy_valid || phy_ready;
    assign w_accept   = (r_state == S_OWN) && w_own_valid && w_can_load;

    always_comb begin
        usr_ready = '0;
        for (int i = 0; i < N; i++) begin
            usr_ready[i] = (r_state == S_OWN) && (r_gnt_id == 3'(i)) && w_can_load;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_rr_found)              w_state_nxt = S_OWN;
            S_OWN:  if (w_accept && w_own_last)  w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt_id    <= 3'd0;
            r_last_id   <= 3'(N - 1);
            r_phy_data  <= 8'h00;
            r_phy_rs    <= 1'b0;
            r_phy_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_rr_found) begin
                r_gnt_id <= w_rr_id;
            end
            if (r_state == S_OWN && w_state_nxt == S_IDLE) begin
                r_last_id <= r_gnt_id;
            end
            // A load overrides a drain, giving back-to-back beats with no bubble.
            if (w_accept) begin
                r_phy_data  <= w_own_data;
                r_phy_rs    <= w_own_rs;
                r_phy_valid <= 1'b1;
            end else if (phy_ready) begin
                r_phy_valid <= 1'b0;
            end
        end
    end

    assign phy_data  = r_phy_data;
    assign phy_rs    = r_phy_rs;
    assign phy_valid = r_phy_valid;
    assign gnt_id    = r_gnt_id;
    assign busy      = (r_state == S_OWN);

endmodule
